line_buffer_ring: RTL and testbench
===================================

Name: line_buffer_ring

Overview:
- Parametrised K-row line buffer for sliding-window image kernels (3x3, 5x5, 7x7, ...).
- Holds K-1 previous rows in K-1 single-clock RAMs and writes them in rotation, oldest row overwritten first.
- For every accepted input pixel it emits one vertical column of K pixels at the same x position.
- Sits between the pixel stream source and the window/convolution stage; generalises the fixed two-RAM, 3-row priming buffer.

Parameters:
- P_KERNEL_ROWS, 3, K = rows per output column (>=2); the block instantiates K-1 line RAMs.
- P_ROW_WIDTH, 256, pixels per image row; RAM depth.
- P_FRAME_ROWS, 256, rows per frame.
- P_DATA_WIDTH, 8, bits per pixel.
- P_ADDR_WIDTH, 12, column address and counter width; must satisfy 2^P_ADDR_WIDTH >= max(P_ROW_WIDTH, P_FRAME_ROWS).

Ports:
- i_clk  in  1  single clock for all logic and RAMs.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input pixel strobe; no backpressure.
- i_sof  in  1  start of frame, qualified by i_valid; marks pixel (0,0).
- i_data  in  P_DATA_WIDTH  input pixel.
- o_valid  out  1  column output valid.
- o_col_data  out  P_KERNEL_ROWS*P_DATA_WIDTH  pixel column; MSB slice = oldest row (y-K+1), LSB slice = current row y.
- o_col  out  P_ADDR_WIDTH  x of the emitted column.
- o_row  out  P_ADDR_WIDTH  y of the current (newest) row of the emitted column.
- o_eol  out  1  emitted column is x = P_ROW_WIDTH-1.
- o_eof  out  1  emitted column is the last pixel of the frame.

Behaviour:
- Reset, asynchronous on i_rst_n low: all outputs 0; column, row, fill and rotation pointers 0. RAM contents are not cleared.
- Counters:
  - col advances on each i_valid and wraps from P_ROW_WIDTH-1 to 0.
  - On a column wrap, row increments, and the write pointer wp advances modulo K-1.
  - fill counts completed rows and saturates at K-1.
- Per accepted pixel at cycle t:
  - All K-1 RAMs are read at address col.
  - The pixel, col and wp are registered.
- At cycle t+1:
  - The registered pixel is written to RAM[wp] at the registered col. RAM[wp] holds the oldest row, which was already read at t, so there is no read-during-write hazard.
  - o_col_data is formed by ordering the RAM outputs oldest to newest, starting at wp and rotating, with the registered pixel as LSB.
- Latency: exactly 1 cycle from i_valid to o_valid. Throughput is 1 pixel per clock, and back-to-back pixels are supported.
- o_valid = registered i_valid AND (fill == K-1). Rows 0..K-2 of each frame are priming rows only, so no output is produced for them.
- o_col, o_row, o_eol and o_eof are aligned with o_valid. They hold their last value while o_valid is 0. o_eol and o_eof are 1-cycle pulses.
- End of frame: after the pixel at (P_ROW_WIDTH-1, P_FRAME_ROWS-1), col, row, fill and wp all return to 0. The next frame primes again.
- i_sof with i_valid, at any point including mid-row or mid-priming:
  - col, row, fill and wp are forced to 0 before the pixel is processed, so that pixel is (0,0).
  - No output is produced for it.
  - Any column already in flight from the previous cycle still completes normally.
- i_valid low: counters, pointers and RAMs hold; o_valid deasserts the next cycle.
- Gaps of any length between pixels are allowed.
- Reset asserted mid-frame: immediate return to the reset state. The next frame must start with i_sof; without it, the next pixel is still treated as (0,0).

Decomposition:
- Package line_buffer_pkg:
  - clog2 function.
  - Pointer width localparam for K-1 ring entries.
  - Per-slice index helpers for packing o_col_data.
- One sub-module, line_buffer_sdp_ram:
  - Simple dual-port RAM on one clock: write port A, read port B.
  - 1-cycle registered read; P_DATA_WIDTH x P_ROW_WIDTH.
  - Generated K-1 times.

Test Plan:
- K=3, ROW_WIDTH=4, FRAME_ROWS=4, pixel value = 16*y+x, continuous valid:
  - No o_valid during rows 0-1.
  - At (x=2, y=2) o_col_data = {0x02, 0x12, 0x22}, with o_valid exactly 1 cycle after input.
- Same config, row 3:
  - Ring rotation gives (x=0, y=3) = {0x10, 0x20, 0x30}.
  - o_eol at x=3; o_eof at (3,3) only.
- K=5, ROW_WIDTH=8: 4 priming rows produce no output; the first valid column is (0,4) = {0x00, 0x10, 0x20, 0x30, 0x40}.
- Random i_valid gaps (~50% duty), K=3: the output sequence is identical to the continuous run, and o_valid never asserts without a preceding i_valid.
- i_sof asserted at (x=2, y=2):
  - That pixel becomes (0,0) and no o_valid follows for 2 rows.
  - Re-priming is correct afterwards.
- i_rst_n pulsed low mid-row 3:
  - All outputs are 0 asynchronously.
  - A fresh frame then reproduces the first scenario exactly.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_pkg
// Shared helpers for the K-row line buffer ring:
//   clog2       - ceiling log2 for parameter elaboration
//   ptr_width   - pointer width for an N-entry ring (never below 1 bit)
//   slice_lsb   - LSB bit position of a column slot (slot 0 = oldest row = MSB)
//   ring_idx    - RAM index holding ring slot 'offset' when the oldest is 'base'
// -----------------------------------------------------------------------------
package line_buffer_pkg;

    // Default kernel height; the ring then holds LB_DEFAULT_ROWS-1 RAMs.
    localparam int LB_DEFAULT_ROWS = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic int ptr_width(input int entries);
        return (entries <= 1) ? 1 : clog2(entries);
    endfunction

    // Pointer width for the K-1 entry rotation of the default configuration.
    localparam int LB_PTR_W = ptr_width(LB_DEFAULT_ROWS - 1);

    function automatic int slice_lsb(input int slot, input int rows, input int data_width);
        return (rows - 1 - slot) * data_width;
    endfunction

    function automatic int ring_idx(input int base, input int offset, input int entries);
        return (base + offset) % entries;
    endfunction

endpackage

// File: rtl/line_buffer_ring_if.sv
// -----------------------------------------------------------------------------
// line_buffer_ring_if
// Pixel-in / column-out bundle of the line buffer ring.
//   i_valid, i_sof, i_data              : pixel stream into the buffer
//   o_valid, o_col_data, o_col, o_row,
//   o_eol, o_eof                        : vertical column out of the buffer
// master = pixel source / column consumer, slave = line buffer.
// -----------------------------------------------------------------------------
interface line_buffer_ring_if #(
    parameter int P_KERNEL_ROWS = 3,
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_ADDR_WIDTH  = 12
);
    logic                                   i_valid;
    logic                                   i_sof;
    logic [P_DATA_WIDTH-1:0]                i_data;
    logic                                   o_valid;
    logic [P_KERNEL_ROWS*P_DATA_WIDTH-1:0]  o_col_data;
    logic [P_ADDR_WIDTH-1:0]                o_col;
    logic [P_ADDR_WIDTH-1:0]                o_row;
    logic                                   o_eol;
    logic                                   o_eof;

    modport master (
        output i_valid, i_sof, i_data,
        input  o_valid, o_col_data, o_col, o_row, o_eol, o_eof
    );

    modport slave (
        input  i_valid, i_sof, i_data,
        output o_valid, o_col_data, o_col, o_row, o_eol, o_eof
    );
endinterface

// File: rtl/line_buffer_sdp_ram.sv
// -----------------------------------------------------------------------------
// line_buffer_sdp_ram
// Simple dual-port RAM, one clock: write port A, registered read port B.
//   i_clk, i_rst_n      : clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata: write port
//   i_re/i_raddr        : read request, data appears on o_rdata next cycle
//   o_rdata             : read register, holds while i_re is low
// Array contents are not reset.
// -----------------------------------------------------------------------------
module line_buffer_sdp_ram #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_DEPTH      = 256,
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [P_ADDR_WIDTH-1:0] i_waddr,
    input  logic [P_DATA_WIDTH-1:0] i_wdata,
    input  logic                    i_re,
    input  logic [P_ADDR_WIDTH-1:0] i_raddr,
    output logic [P_DATA_WIDTH-1:0] o_rdata
);
    logic [P_DATA_WIDTH-1:0] mem_r [P_DEPTH];
    logic [P_DATA_WIDTH-1:0] rdata_r;

    // Storage array write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; reads old data when the same address is written.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_r <= '0;
        end else if (i_re) begin
            rdata_r <= mem_r[i_raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign o_rdata = rdata_r;
endmodule

// File: rtl/line_buffer_ring.sv
// -----------------------------------------------------------------------------
// line_buffer_ring
// K-row line buffer for sliding-window kernels. K-1 previous rows live in K-1
// line RAMs written in rotation (oldest row overwritten first). Each accepted
// pixel produces, one cycle later, the vertical column of K pixels at its x.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : i_valid/i_sof/i_data in;
//                    o_valid/o_col_data/o_col/o_row/o_eol/o_eof out
// o_col_data: MSB slice = oldest row (y-K+1), LSB slice = current row y.
// -----------------------------------------------------------------------------
module line_buffer_ring
    import line_buffer_pkg::*;
#(
    parameter int P_KERNEL_ROWS = 3,
    parameter int P_ROW_WIDTH   = 256,
    parameter int P_FRAME_ROWS  = 256,
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_ADDR_WIDTH  = 12
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    line_buffer_ring_if.slave  bus
);
    localparam int NUM_RAMS = P_KERNEL_ROWS - 1;
    localparam int PTR_W    = ptr_width(NUM_RAMS);
    localparam int RAM_AW   = ptr_width(P_ROW_WIDTH);
    localparam int AW       = P_ADDR_WIDTH;
    localparam int DW       = P_DATA_WIDTH;

    localparam logic [AW-1:0]    COL_LAST  = AW'(P_ROW_WIDTH - 1);
    localparam logic [AW-1:0]    ROW_LAST  = AW'(P_FRAME_ROWS - 1);
    localparam logic [AW-1:0]    FILL_FULL = AW'(NUM_RAMS);
    localparam logic [PTR_W-1:0] WP_LAST   = PTR_W'(NUM_RAMS - 1);

    // Position / rotation state
    logic [AW-1:0]    col_r, row_r, fill_r;
    logic [PTR_W-1:0] wp_r;
    // Position seen by the current pixel (after a possible start-of-frame clear)
    logic [AW-1:0]    col_eff_s, row_eff_s, fill_eff_s;
    logic [PTR_W-1:0] wp_eff_s;
    logic [AW-1:0]    col_nxt_s, row_nxt_s, fill_nxt_s;
    logic [PTR_W-1:0] wp_nxt_s;
    logic             emit_s;

    // Write stage: pixel waiting to be stored into the oldest-row RAM
    logic              wen_r;
    logic [DW-1:0]     pix_r;
    logic [RAM_AW-1:0] wcol_r;
    logic [PTR_W-1:0]  wwp_r;

    // Registered outputs
    logic          valid_r, eol_r, eof_r;
    logic [AW-1:0] out_col_r, out_row_r;

    logic [DW-1:0]               ram_rdata_s [NUM_RAMS];
    logic [NUM_RAMS-1:0]         ram_we_s;
    logic [P_KERNEL_ROWS*DW-1:0] col_data_s;

    // Start of frame clears position before the pixel is processed.
    always_comb begin
        if (bus.i_valid && bus.i_sof) begin
            col_eff_s  = '0;
            row_eff_s  = '0;
            fill_eff_s = '0;
            wp_eff_s   = '0;
        end else begin
            col_eff_s  = col_r;
            row_eff_s  = row_r;
            fill_eff_s = fill_r;
            wp_eff_s   = wp_r;
        end
    end

    // Next position: column wrap advances row, fill and the rotation pointer;
    // the last pixel of the frame returns everything to zero.
    always_comb begin
        col_nxt_s  = col_r;
        row_nxt_s  = row_r;
        fill_nxt_s = fill_r;
        wp_nxt_s   = wp_r;
        if (bus.i_valid) begin
            if (col_eff_s == COL_LAST) begin
                col_nxt_s = '0;
                if (row_eff_s == ROW_LAST) begin
                    row_nxt_s  = '0;
                    fill_nxt_s = '0;
                    wp_nxt_s   = '0;
                end else begin
                    row_nxt_s  = row_eff_s + AW'(1'b1);
                    fill_nxt_s = (fill_eff_s == FILL_FULL) ? FILL_FULL : fill_eff_s + AW'(1'b1);
                    wp_nxt_s   = (wp_eff_s == WP_LAST) ? '0 : wp_eff_s + PTR_W'(1'b1);
                end
            end else begin
                col_nxt_s  = col_eff_s + AW'(1'b1);
                row_nxt_s  = row_eff_s;
                fill_nxt_s = fill_eff_s;
                wp_nxt_s   = wp_eff_s;
            end
        end else begin
            col_nxt_s  = col_r;
            row_nxt_s  = row_r;
            fill_nxt_s = fill_r;
            wp_nxt_s   = wp_r;
        end
    end

    // A column is emitted only once K-1 full rows are buffered.
    assign emit_s = bus.i_valid && (fill_eff_s == FILL_FULL);

    // Position and rotation registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_r  <= '0;
            row_r  <= '0;
            fill_r <= '0;
            wp_r   <= '0;
        end else begin
            col_r  <= col_nxt_s;
            row_r  <= row_nxt_s;
            fill_r <= fill_nxt_s;
            wp_r   <= wp_nxt_s;
        end
    end

    // Write stage; holds while idle so the column output stays stable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wen_r  <= 1'b0;
            pix_r  <= '0;
            wcol_r <= '0;
            wwp_r  <= '0;
        end else if (bus.i_valid) begin
            wen_r  <= 1'b1;
            pix_r  <= bus.i_data;
            wcol_r <= col_eff_s[RAM_AW-1:0];
            wwp_r  <= wp_eff_s;
        end else begin
            wen_r  <= 1'b0;
        end
    end

    // Column metadata; col/row hold between emitted columns, eol/eof pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r   <= 1'b0;
            out_col_r <= '0;
            out_row_r <= '0;
            eol_r     <= 1'b0;
            eof_r     <= 1'b0;
        end else if (emit_s) begin
            valid_r   <= 1'b1;
            out_col_r <= col_eff_s;
            out_row_r <= row_eff_s;
            eol_r     <= (col_eff_s == COL_LAST);
            eof_r     <= (col_eff_s == COL_LAST) && (row_eff_s == ROW_LAST);
        end else begin
            valid_r   <= 1'b0;
            eol_r     <= 1'b0;
            eof_r     <= 1'b0;
        end
    end

    // RAM[wwp_r] holds the oldest row, already read for this pixel, so it is
    // overwritten with the newest one.
    for (genvar g = 0; g < NUM_RAMS; g++) begin : g_ram
        assign ram_we_s[g] = wen_r && (wwp_r == PTR_W'(g));

        line_buffer_sdp_ram #(
            .P_DATA_WIDTH (DW),
            .P_DEPTH      (P_ROW_WIDTH),
            .P_ADDR_WIDTH (RAM_AW)
        ) u_ram (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (ram_we_s[g]),
            .i_waddr (wcol_r),
            .i_wdata (pix_r),
            .i_re    (bus.i_valid),
            .i_raddr (col_eff_s[RAM_AW-1:0]),
            .o_rdata (ram_rdata_s[g])
        );
    end

    // Column assembly: oldest row at wwp_r, rotating toward the newest.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        col_data_s          = '0;
        col_data_s[DW-1:0]  = pix_r;
        for (int j = 0; j < NUM_RAMS; j++) begin
            idx_v = PTR_W'(ring_idx(int'(wwp_r), j, NUM_RAMS));
            col_data_s[slice_lsb(j, P_KERNEL_ROWS, DW) +: DW] = ram_rdata_s[idx_v];
        end
    end

    assign bus.o_valid    = valid_r;
    assign bus.o_col_data = col_data_s;
    assign bus.o_col      = out_col_r;
    assign bus.o_row      = out_row_r;
    assign bus.o_eol      = eol_r;
    assign bus.o_eof      = eof_r;
endmodule

// File: tb/tb_line_buffer_ring.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_ring
// Two instances: A (K=3, 4x4 frame) and B (K=5, 8x8 frame). A reference
// model stores the current frame as an image array indexed by (y,x) and forms
// each expected column directly from it.
// -----------------------------------------------------------------------------
module tb_line_buffer_ring;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    line_buffer_ring_if #(.P_KERNEL_ROWS(3), .P_DATA_WIDTH(8), .P_ADDR_WIDTH(12)) ifa ();
    line_buffer_ring_if #(.P_KERNEL_ROWS(5), .P_DATA_WIDTH(8), .P_ADDR_WIDTH(12)) ifb ();

    line_buffer_ring #(
        .P_KERNEL_ROWS(3), .P_ROW_WIDTH(4), .P_FRAME_ROWS(4),
        .P_DATA_WIDTH(8), .P_ADDR_WIDTH(12)
    ) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa)
    );

    line_buffer_ring #(
        .P_KERNEL_ROWS(5), .P_ROW_WIDTH(8), .P_FRAME_ROWS(8),
        .P_DATA_WIDTH(8), .P_ADDR_WIDTH(12)
    ) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model state
    int sel;                 // 0 = instance A, 1 = instance B
    int mk, mw, mfr;         // kernel rows, row width, frame rows
    int m_pos;               // raster position of the next pixel in the frame
    int m_last_col, m_last_row;
    int img [8][8];
    logic [63:0] last_obs_col;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [7:0] d);
        if (sel == 0) begin
            ifa.i_valid = v;   ifa.i_sof = s;    ifa.i_data = d;
            ifb.i_valid = 1'b0; ifb.i_sof = 1'b0; ifb.i_data = 8'h00;
        end else begin
            ifb.i_valid = v;   ifb.i_sof = s;    ifb.i_data = d;
            ifa.i_valid = 1'b0; ifa.i_sof = 1'b0; ifa.i_data = 8'h00;
        end
    endtask

    task automatic model_start(input int which, input int k, input int w, input int fr);
        sel = which; mk = k; mw = w; mfr = fr;
        m_pos = 0; m_last_col = 0; m_last_row = 0;
    endtask

    // One clock: present (v, s), advance one edge, compare with the model.
    task automatic step(input bit v, input bit s, input bit rnd);
        int x, y;
        logic [7:0] d;
        bit ev, eeol, eeof;
        logic [63:0] ecol;
        logic ov, oeol, oeof;
        logic [63:0] ocd, oc, orow;

        if (v && s) m_pos = 0;
        x = m_pos % mw;
        y = m_pos / mw;
        d = rnd ? 8'($urandom_range(0, 255)) : 8'(16 * y + x);
        drive(v, s, d);
        @(posedge clk);
        #1;

        ev = 1'b0; eeol = 1'b0; eeof = 1'b0; ecol = 64'h0;
        if (v) begin
            img[y][x] = int'(d);
            ev = (y >= mk - 1);
            if (ev) begin
                for (int r = 0; r < mk; r++) begin
                    ecol[(mk - 1 - r) * 8 +: 8] = 8'(img[y - mk + 1 + r][x]);
                end
                m_last_col = x;
                m_last_row = y;
                eeol = (x == mw - 1);
                eeof = eeol && (y == mfr - 1);
            end
            m_pos = (m_pos + 1) % (mw * mfr);
        end

        if (sel == 0) begin
            ov = ifa.o_valid; ocd = 64'(ifa.o_col_data); oc = 64'(ifa.o_col);
            orow = 64'(ifa.o_row); oeol = ifa.o_eol; oeof = ifa.o_eof;
        end else begin
            ov = ifb.o_valid; ocd = 64'(ifb.o_col_data); oc = 64'(ifb.o_col);
            orow = 64'(ifb.o_row); oeol = ifb.o_eol; oeof = ifb.o_eof;
        end
        last_obs_col = ocd;

        chk("o_valid", 64'(ov), 64'(ev));
        chk("o_eol", 64'(oeol), 64'(eeol));
        chk("o_eof", 64'(oeof), 64'(eeof));
        chk("o_col", oc, 64'(m_last_col));
        chk("o_row", orow, 64'(m_last_row));
        if (ev) chk("o_col_data", ocd, ecol);
    endtask

    initial begin
        int acc;
        bit v;

        sel = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        model_start(0, 3, 4, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ifa.o_valid), 64'h0);
        chk("rst_col_data", 64'(ifa.o_col_data), 64'h0);
        chk("rst_col", 64'(ifa.o_col), 64'h0);
        chk("rst_row", 64'(ifa.o_row), 64'h0);
        chk("rst_eol_eof", {62'h0, ifa.o_eol, ifa.o_eof}, 64'h0);
        chk("rst_b_valid", 64'(ifb.o_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame, then a second one without sof (end-of-frame wrap).
        for (int i = 0; i < 32; i++) begin
            step(1'b1, i == 0, 1'b0);
            if (i == 10 || i == 26) chk("col_x2_y2", last_obs_col, 64'h021222);
            if (i == 12 || i == 28) chk("col_x0_y3", last_obs_col, 64'h102030);
        end
        step(1'b0, 1'b0, 1'b0);

        // Random gaps, pixel values from position.
        acc = 0;
        while (acc < 16) begin
            v = 1'($urandom_range(0, 1));
            step(v, v && (acc == 0), 1'b0);
            if (v && acc == 10) chk("gap_col_x2_y2", last_obs_col, 64'h021222);
            acc += int'(v);
        end

        // Random gaps, random pixel values, two frames.
        acc = 0;
        while (acc < 32) begin
            v = 1'($urandom_range(0, 1));
            step(v, 1'b0, 1'b1);
            acc += int'(v);
        end

        // sof at (2,2): that pixel becomes (0,0) and the frame re-primes.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 10) chk("resof_col_x2_y2", last_obs_col, 64'h021222);
        end

        // Reset pulse mid-row 3.
        for (int i = 0; i < 14; i++) step(1'b1, i == 0, 1'b0);
        drive(1'b0, 1'b0, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ifa.o_valid), 64'h0);
        chk("arst_col_data", 64'(ifa.o_col_data), 64'h0);
        chk("arst_col", 64'(ifa.o_col), 64'h0);
        chk("arst_row", 64'(ifa.o_row), 64'h0);
        chk("arst_eol_eof", {62'h0, ifa.o_eol, ifa.o_eof}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_start(0, 3, 4, 4);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 10) chk("post_rst_col_x2_y2", last_obs_col, 64'h021222);
            if (i == 12) chk("post_rst_col_x0_y3", last_obs_col, 64'h102030);
        end
        step(1'b0, 1'b0, 1'b0);

        // Instance B: K=5, four priming rows.
        model_start(1, 5, 8, 8);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, i == 0, 1'b0);
            if (i == 32) chk("b_col_x0_y4", last_obs_col, 64'h0010203040);
        end
        acc = 0;
        while (acc < 64) begin
            v = 1'($urandom_range(0, 1));
            step(v, 1'b0, 1'b1);
            acc += int'(v);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
